// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame timing.
// The transmit path imports the same package, so both sides agree on the defaults.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int CLKS_PER_BIT_DEFAULT = 868;
    localparam int DATA_BITS_DEFAULT    = 8;

    // The receiver waits this many clocks after the start edge before sampling the start bit.
    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Valid/ready byte stream from the UART receiver to its consumer.
// The receiver drives the master side and the consumer drives the slave side.
interface uart_rx_if #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS_DEFAULT
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value
// so idle-high lines do not produce a false edge when reset releases.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a local clock counter, valid/ready output,
// one-cycle framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int HALF_BIT     = half_bit(CLKS_PER_BIT),
    parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master rx_bus,
    output logic      frame_err,
    output logic      overrun,
    output logic      busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev;
    logic                 fall;
    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Frames start only on a high-to-low transition, so a line stuck low after a
    // break (or through reset) cannot retrigger the receiver.
    assign fall = rx_prev & ~rx_s;

    assign rx_bus.rx_data  = data_reg;
    assign rx_bus.rx_valid = valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev   <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_prev   <= rx_s;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (valid_reg && rx_bus.rx_ready) begin
                valid_reg <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (fall) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        shift_reg <= (shift_reg >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Leave at mid-stop so a start edge immediately after the stop bit is seen.
                // A byte landing in the same cycle as an accept overrides the clear above.
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (rx_s) begin
                            data_reg  <= shift_reg;
                            valid_reg <= 1'b1;
                            overrun   <= valid_reg & ~rx_bus.rx_ready;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a fast instance (16 clocks/bit) for functional cases
// and a default-rate instance (868 clocks/bit) for end-to-end latency.
module tb_uart_rx;

    localparam int CPB    = 16;
    localparam int HALF   = 8;
    localparam int CPB_S  = 868;
    localparam int HALF_S = 434;
    localparam int LAT_S  = 2 + HALF_S + 9 * CPB_S + 1;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic rx_slow;
    logic frame_err, overrun, busy;
    logic frame_err_s, overrun_s, busy_s;

    uart_rx_if #(.DATA_BITS(8)) bus  ();
    uart_rx_if #(.DATA_BITS(8)) sbus ();

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .HALF_BIT     (HALF),
        .DATA_BITS    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_bus    (bus),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    uart_rx #(
        .CLKS_PER_BIT (CPB_S),
        .HALF_BIT     (HALF_S),
        .DATA_BITS    (8)
    ) dut_slow (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_slow),
        .rx_bus    (sbus),
        .frame_err (frame_err_s),
        .overrun   (overrun_s),
        .busy      (busy_s)
    );

    int checks = 0;
    int passed = 0;
    int failed = 0;

    int cycle_ctr    = 0;
    int valid_cycles = 0;
    int ferr_count   = 0;
    int ovr_count    = 0;
    int ferr_count_s = 0;
    int rise_cycle   = -1;
    int start_cycle  = 0;
    logic slow_prev  = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] slow_q[$];

    always @(posedge clk) cycle_ctr <= cycle_ctr + 1;

    // Passive monitor: counts pulses and records every accepted byte.
    always @(negedge clk) begin
        if (bus.rx_valid) valid_cycles <= valid_cycles + 1;
        if (bus.rx_valid && bus.rx_ready) rx_q.push_back(bus.rx_data);
        if (frame_err) ferr_count <= ferr_count + 1;
        if (overrun) ovr_count <= ovr_count + 1;
        if (frame_err_s) ferr_count_s <= ferr_count_s + 1;
        if (sbus.rx_valid && !slow_prev) rise_cycle <= cycle_ctr;
        slow_prev <= sbus.rx_valid;
        if (sbus.rx_valid && sbus.rx_ready) slow_q.push_back(sbus.rx_data);
    end

    function automatic logic [31:0] q_at(input int idx);
        if (idx < rx_q.size()) return {24'h0, rx_q[idx]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bits(input logic sel, input logic v, input int n);
        @(posedge clk);
        #1;
        if (sel) rx_slow = v;
        else     rx      = v;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic apply_stimulus(input logic sel, input logic [7:0] b, input logic stop_bit);
        int n;
        n = sel ? CPB_S : CPB;
        @(posedge clk);
        #1;
        start_cycle = cycle_ctr;
        if (sel) rx_slow = 1'b0;
        else     rx      = 1'b0;
        repeat (n - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_bits(sel, b[i], n);
        drive_bits(sel, stop_bit, n);
    endtask

    int vb, qb, fb, ob;

    initial begin
        rst           = 1'b1;
        rx            = 1'b1;
        rx_slow       = 1'b1;
        bus.rx_ready  = 1'b1;
        sbus.rx_ready = 1'b1;
        repeat (4) @(negedge clk);

        check_output("reset_rx_data", {24'h0, bus.rx_data}, 32'h0);
        check_output("reset_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
        check_output("reset_frame_err", {31'h0, frame_err}, 32'h0);
        check_output("reset_overrun", {31'h0, overrun}, 32'h0);
        check_output("reset_busy", {31'h0, busy}, 32'h0);
        check_output("reset_slow_valid", {31'h0, sbus.rx_valid}, 32'h0);
        check_output("reset_slow_busy", {31'h0, busy_s}, 32'h0);

        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        $display("[TB] single byte 0xA5");
        vb = valid_cycles; qb = rx_q.size(); fb = ferr_count;
        apply_stimulus(1'b0, 8'hA5, 1'b1);
        drive_bits(1'b0, 1'b1, 2 * CPB);
        check_output("t1_valid_cycles", valid_cycles - vb, 1);
        check_output("t1_count", rx_q.size() - qb, 1);
        check_output("t1_data", q_at(qb), 32'hA5);
        check_output("t1_frame_err", ferr_count - fb, 0);

        $display("[TB] back-to-back 0x3C 0x81");
        qb = rx_q.size(); fb = ferr_count; ob = ovr_count;
        apply_stimulus(1'b0, 8'h3C, 1'b1);
        apply_stimulus(1'b0, 8'h81, 1'b1);
        drive_bits(1'b0, 1'b1, 2 * CPB);
        check_output("t2_count", rx_q.size() - qb, 2);
        check_output("t2_first", q_at(qb), 32'h3C);
        check_output("t2_second", q_at(qb + 1), 32'h81);
        check_output("t2_errors", (ferr_count - fb) + (ovr_count - ob), 0);

        $display("[TB] framing error then recovery");
        vb = valid_cycles; qb = rx_q.size(); fb = ferr_count;
        apply_stimulus(1'b0, 8'h55, 1'b0);
        drive_bits(1'b0, 1'b1, CPB);
        check_output("t3_frame_err", ferr_count - fb, 1);
        check_output("t3_no_valid", valid_cycles - vb, 0);
        apply_stimulus(1'b0, 8'h0F, 1'b1);
        drive_bits(1'b0, 1'b1, 2 * CPB);
        check_output("t3_recover_count", rx_q.size() - qb, 1);
        check_output("t3_recover_data", q_at(qb), 32'h0F);

        $display("[TB] overrun with consumer stalled");
        @(posedge clk);
        #1 bus.rx_ready = 1'b0;
        qb = rx_q.size(); ob = ovr_count;
        apply_stimulus(1'b0, 8'h11, 1'b1);
        drive_bits(1'b0, 1'b1, CPB);
        check_output("t4_no_overrun_first", ovr_count - ob, 0);
        apply_stimulus(1'b0, 8'h22, 1'b1);
        drive_bits(1'b0, 1'b1, CPB);
        @(negedge clk);
        check_output("t4_overrun", ovr_count - ob, 1);
        check_output("t4_valid_held", {31'h0, bus.rx_valid}, 32'h1);
        check_output("t4_data_overwritten", {24'h0, bus.rx_data}, 32'h22);
        check_output("t4_no_transfer", rx_q.size() - qb, 0);
        @(posedge clk);
        #1 bus.rx_ready = 1'b1;
        @(negedge clk);
        check_output("t4_valid_before_accept", {31'h0, bus.rx_valid}, 32'h1);
        @(negedge clk);
        check_output("t4_valid_dropped", {31'h0, bus.rx_valid}, 32'h0);
        repeat (2) @(negedge clk);
        check_output("t4_accept_count", rx_q.size() - qb, 1);
        check_output("t4_accept_data", q_at(qb), 32'h22);

        $display("[TB] start glitch");
        vb = valid_cycles; fb = ferr_count;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_output("t5_busy_in_start", {31'h0, busy}, 32'h1);
        @(negedge clk);
        check_output("t5_busy_released", {31'h0, busy}, 32'h0);
        drive_bits(1'b0, 1'b1, 2 * CPB);
        check_output("t5_no_valid", valid_cycles - vb, 0);
        check_output("t5_no_frame_err", ferr_count - fb, 0);

        $display("[TB] reset during a frame");
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB - 1) @(posedge clk);
        drive_bits(1'b0, 1'b1, 3 * CPB + HALF);
        @(negedge clk);
        check_output("t6_busy_mid_frame", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_output("t6_rst_busy", {31'h0, busy}, 32'h0);
        check_output("t6_rst_valid", {31'h0, bus.rx_valid}, 32'h0);
        check_output("t6_rst_data", {24'h0, bus.rx_data}, 32'h0);
        check_output("t6_rst_pulses", {30'h0, frame_err, overrun}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        qb = rx_q.size(); fb = ferr_count;
        drive_bits(1'b0, 1'b1, 2 * CPB);
        apply_stimulus(1'b0, 8'h7E, 1'b1);
        drive_bits(1'b0, 1'b1, 2 * CPB);
        check_output("t6_count", rx_q.size() - qb, 1);
        check_output("t6_data", q_at(qb), 32'h7E);
        check_output("t6_frame_err", ferr_count - fb, 0);

        $display("[TB] default baud 0xC3");
        apply_stimulus(1'b1, 8'hC3, 1'b1);
        drive_bits(1'b1, 1'b1, CPB_S);
        repeat (4) @(negedge clk);
        check_output("t6s_count", slow_q.size(), 1);
        check_output("t6s_data", (slow_q.size() > 0) ? {24'h0, slow_q[0]} : 32'hDEAD_BEEF, 32'hC3);
        check_output("t6s_latency", rise_cycle - start_cycle, LAT_S);
        check_output("t6s_frame_err", ferr_count_s, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
